// File: rtl/sobel_window_conv.sv
// -----------------------------------------------------------------------------
// sobel_window_conv
// Sobel 3x3 convolution stage for a raster-order 12-bit grayscale stream.
// Two previous lines are kept in line-buffer RAM, a 3x3 window is built from
// them plus the incoming pixel, and signed Gx/Gy gradients are produced for
// every accepted pixel. Windows that reach past the top or left frame edge
// give zero gradients so that the output pixel count equals the input count.
// Results are centred on (row-1, col-1) of the accepted pixel. The latency is
// two clocks.
//
// Ports:
//   iCLK     in   1   pixel clock, rising edge
//   iRST     in   1   asynchronous active-high reset
//   iDATA    in  12   unsigned grayscale pixel
//   iDVAL    in   1   iDATA valid this cycle
//   iSOF     in   1   start of frame (this pixel, or the next one if iDVAL=0)
//   oSobelX  out 15   signed Gx, two's complement
//   oSobelY  out 15   signed Gy, two's complement
//   oDVAL    out  1   oSobelX/oSobelY valid
// -----------------------------------------------------------------------------
module sobel_window_conv #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [11:0] iDATA,
    input  logic        iDVAL,
    input  logic        iSOF,
    output logic [14:0] oSobelX,
    output logic [14:0] oSobelY,
    output logic        oDVAL
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Sum of a, 2*b and c. The largest value (4*4095) fits in 15-bit signed,
    // so every difference of two such sums also fits without overflow.
    function automatic logic signed [14:0] weighted_sum(
        input logic [11:0] a,
        input logic [11:0] b,
        input logic [11:0] c
    );
        logic signed [14:0] ea;
        logic signed [14:0] eb;
        logic signed [14:0] ec;
        ea = signed'({3'b000, a});
        eb = signed'({3'b000, b});
        ec = signed'({3'b000, c});
        return ea + eb + eb + ec;
    endfunction

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] pix_col_s;
    logic [RW-1:0] pix_row_s;
    logic [CW-1:0] col_nxt_s;
    logic [RW-1:0] row_nxt_s;

    logic [11:0] lb0_r [IMG_WIDTH];
    logic [11:0] lb1_r [IMG_WIDTH];
    logic [11:0] lb0_rd_s;
    logic [11:0] lb1_rd_s;

    logic [11:0] p00_r, p01_r, p02_r;
    logic [11:0] p10_r, p11_r, p12_r;
    logic [11:0] p20_r, p21_r, p22_r;
    logic        interior_r;
    logic        vld_r;

    logic signed [14:0] gx_s;
    logic signed [14:0] gy_s;

    // Position of the pixel on iDATA: iSOF forces it to the frame origin.
    always_comb begin
        pix_col_s = col_r;
        pix_row_s = row_r;
        if (iSOF) begin
            pix_col_s = {CW{1'b0}};
            pix_row_s = {RW{1'b0}};
        end else begin
            pix_col_s = col_r;
            pix_row_s = row_r;
        end
    end

    // Next column/row: advance past the accepted pixel, wrapping at line and
    // frame ends; an iSOF without a pixel just parks the counters at origin.
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (iDVAL) begin
            if (pix_col_s == COL_LAST) begin
                col_nxt_s = {CW{1'b0}};
                if (pix_row_s == ROW_LAST) begin
                    row_nxt_s = {RW{1'b0}};
                end else begin
                    row_nxt_s = pix_row_s + RW'(1);
                end
            end else begin
                col_nxt_s = pix_col_s + CW'(1);
                row_nxt_s = pix_row_s;
            end
        end else if (iSOF) begin
            col_nxt_s = {CW{1'b0}};
            row_nxt_s = {RW{1'b0}};
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
    end

    // Column/row counter registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    // Asynchronous reads happen before the write edge, so a read of the
    // address being written returns the old contents.
    assign lb0_rd_s = lb0_r[pix_col_s];
    assign lb1_rd_s = lb1_r[pix_col_s];

    // Line-buffer writes: new pixel into LB0, LB0's previous line into LB1.
    // Contents are not reset; the border mask hides stale data.
    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            lb0_r[pix_col_s] <= iDATA;
            lb1_r[pix_col_s] <= lb0_rd_s;
        end
    end

    // 3x3 window shift, border mask and valid pipeline stage 1.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            p00_r <= 12'd0; p01_r <= 12'd0; p02_r <= 12'd0;
            p10_r <= 12'd0; p11_r <= 12'd0; p12_r <= 12'd0;
            p20_r <= 12'd0; p21_r <= 12'd0; p22_r <= 12'd0;
            interior_r <= 1'b0;
            vld_r      <= 1'b0;
        end else begin
            vld_r <= iDVAL;
            if (iDVAL) begin
                p00_r <= p01_r; p01_r <= p02_r; p02_r <= lb1_rd_s;
                p10_r <= p11_r; p11_r <= p12_r; p12_r <= lb0_rd_s;
                p20_r <= p21_r; p21_r <= p22_r; p22_r <= iDATA;
                interior_r <= (pix_row_s >= ROW_TWO) && (pix_col_s >= COL_TWO);
            end
        end
    end

    // Gradients: right minus left (Gx), bottom minus top (Gy).
    always_comb begin
        gx_s = weighted_sum(p02_r, p12_r, p22_r) - weighted_sum(p00_r, p10_r, p20_r);
        gy_s = weighted_sum(p20_r, p21_r, p22_r) - weighted_sum(p00_r, p01_r, p02_r);
    end

    // Output registers; values hold while no result is presented.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oSobelX <= 15'd0;
            oSobelY <= 15'd0;
            oDVAL   <= 1'b0;
        end else begin
            oDVAL <= vld_r;
            if (vld_r) begin
                if (interior_r) begin
                    oSobelX <= gx_s;
                    oSobelY <= gy_s;
                end else begin
                    oSobelX <= 15'd0;
                    oSobelY <= 15'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_conv.sv
module tb_sobel_window_conv;

    localparam int W = 4;
    localparam int H = 4;
    localparam logic [14:0] POS = 15'h3FFC;   // +16380
    localparam logic [14:0] NEG = 15'h4004;   // -16380

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [11:0] iDATA = 12'd0;
    logic        iDVAL = 1'b0;
    logic        iSOF = 1'b0;
    logic [14:0] oSobelX;
    logic [14:0] oSobelY;
    logic        oDVAL;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses = 0;
    int snap = 0;
    int pix_id = 0;
    int issue_cyc = 0;
    int lat_cyc = 0;
    bit lat_arm = 1'b0;
    logic [29:0] exp_q[$];
    int          id_q[$];
    logic [14:0] last_x = 15'd0;
    logic [14:0] last_y = 15'd0;

    sobel_window_conv #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
        .oSobelX(oSobelX), .oSobelY(oSobelY), .oDVAL(oDVAL)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Test images: 0 uniform, 1 vertical step, 2 mirrored vertical step,
    // 3 horizontal step, 4 inverted horizontal step.
    function automatic logic [11:0] pix(input int kind, input int r, input int c);
        case (kind)
            0: return 12'd2048;
            1: return (c >= 2) ? 12'd4095 : 12'd0;
            2: return (c < 2)  ? 12'd4095 : 12'd0;
            3: return (r >= 2) ? 12'd4095 : 12'd0;
            4: return (r < 2)  ? 12'd4095 : 12'd0;
            default: return 12'd0;
        endcase
    endfunction

    // Hand-computed interior result {Gx, Gy} for each image.
    function automatic logic [29:0] exp_pair(input int kind);
        case (kind)
            1: return {POS, 15'd0};
            2: return {NEG, 15'd0};
            3: return {15'd0, POS};
            4: return {15'd0, NEG};
            default: return 30'd0;
        endcase
    endfunction

    // Scoreboard monitor: pops on every result, checks hold when idle.
    always @(negedge iCLK) begin
        logic [29:0] e;
        int id;
        if (iRST) begin
            last_x = 15'd0;
            last_y = 15'd0;
        end else if (oDVAL) begin
            pulses++;
            if (lat_arm) begin
                lat_cyc = cyc;
                lat_arm = 1'b0;
            end
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=x%0h/y%0h required=none", oSobelX, oSobelY);
            end else begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                chk($sformatf("gx_pix%0d", id), {17'd0, oSobelX}, {17'd0, e[29:15]});
                chk($sformatf("gy_pix%0d", id), {17'd0, oSobelY}, {17'd0, e[14:0]});
                last_x = e[29:15];
                last_y = e[14:0];
            end
        end else begin
            chk("hold_x", {17'd0, oSobelX}, {17'd0, last_x});
            chk("hold_y", {17'd0, oSobelY}, {17'd0, last_y});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic send_pix(input logic [11:0] d, input logic sof, input logic [29:0] e);
        iDATA = d;
        iSOF  = sof;
        iDVAL = 1'b1;
        exp_q.push_back(e);
        id_q.push_back(pix_id);
        pix_id++;
        @(posedge iCLK);
        #1;
        iDVAL = 1'b0;
        iSOF  = 1'b0;
    endtask

    task automatic send_frame(input int kind, input bit sof, input int gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pix(pix(kind, r, c), sof && (r == 0) && (c == 0),
                         (r >= 2 && c >= 2) ? exp_pair(kind) : 30'd0);
                idle(gap);
            end
        end
    endtask

    task automatic drain(input string name, input int n);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        idle(3);
        chk({name, "_drained"}, exp_q.size(), 32'd0);
        chk({name, "_count"}, pulses - snap, n);
        snap = pulses;
        exp_q.delete();
        id_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_dval", {31'd0, oDVAL}, 32'd0);
        chk("rst_x", {17'd0, oSobelX}, 32'd0);
        chk("rst_y", {17'd0, oSobelY}, 32'd0);
        @(posedge iCLK);
        #3;
        iRST = 1'b0;
        idle(1);

        // Uniform frame, plus first-result latency.
        lat_arm   = 1'b1;
        issue_cyc = cyc;
        send_frame(0, 1'b1, 0);
        drain("uniform", 16);
        chk("latency", lat_cyc - issue_cyc, 32'd2);

        // Step edges in both directions and polarities.
        send_frame(1, 1'b0, 0); drain("vstep", 16);
        send_frame(2, 1'b0, 0); drain("vstep_mirror", 16);
        send_frame(3, 1'b0, 0); drain("hstep", 16);
        send_frame(4, 1'b0, 0); drain("hstep_inv", 16);

        // Gapped input must give the same results.
        send_frame(1, 1'b0, 1); drain("vstep_gapped", 16);

        // iSOF together with a pixel after a partial frame.
        for (int i = 0; i < 6; i++) send_pix((i % 2) ? 12'd4095 : 12'd0, 1'b0, 30'd0);
        send_frame(0, 1'b1, 0);
        drain("sof_dval", 22);

        // iSOF alone after a partial line, then a step frame.
        for (int i = 0; i < 3; i++) send_pix(12'd4095, 1'b0, 30'd0);
        iSOF = 1'b1;
        idle(1);
        iSOF = 1'b0;
        send_frame(1, 1'b0, 0);
        drain("sof_idle", 19);

        // Reset in the middle of row 2, while a nonzero result is presented.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < 2 || c < 3) begin
                    send_pix(pix(1, r, c), 1'b0, (r >= 2 && c >= 2) ? exp_pair(1) : 30'd0);
                end
            end
        end
        @(posedge iCLK);
        #1;
        chk("pre_rst_dval", {31'd0, oDVAL}, 32'd1);
        chk("pre_rst_x", {17'd0, oSobelX}, {17'd0, POS});
        @(negedge iCLK);
        #2;
        chk("pre_rst_count", pulses - snap, 32'd11);
        iRST = 1'b1;
        #1;
        chk("async_rst_dval", {31'd0, oDVAL}, 32'd0);
        chk("async_rst_x", {17'd0, oSobelX}, 32'd0);
        chk("async_rst_y", {17'd0, oSobelY}, 32'd0);
        exp_q.delete();
        id_q.delete();
        repeat (2) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        snap = pulses;
        send_frame(1, 1'b0, 0);
        drain("post_rst", 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_window_conv.md
Name: sobel_window_conv

Overview:
Sobel 3x3 convolution stage feeding the gradient-magnitude/absolute-value stage. It accepts a raster-order 12-bit grayscale pixel stream and buffers two prior lines in on-chip RAM. It builds a 3x3 sliding window and emits signed Sobel X and Y gradients, one result per input pixel. Border pixels, where the window is incomplete, output zero gradients so downstream pixel counts are preserved.

Parameters:
IMG_WIDTH, 640, pixels per line; line-buffer depth; column counter wrap point.
IMG_HEIGHT, 480, lines per frame; row counter wrap point.

Ports:
iCLK  input  1  pixel clock; all logic on rising edge.
iRST  input  1  asynchronous, active-high reset.
iDATA  input  12  unsigned grayscale pixel.
iDVAL  input  1  iDATA valid this cycle.
iSOF  input  1  start of frame; qualifies the pixel accepted in the same cycle, or the next pixel if iDVAL is low.
oSobelX  output  15  signed Gx, two's complement.
oSobelY  output  15  signed Gy, two's complement.
oDVAL  output  1  oSobelX/oSobelY valid.

Behaviour:
- Reset (iRST=1, async):
  - oSobelX, oSobelY = 0; oDVAL = 0.
  - Column counter, row counter, window registers and the valid pipeline = 0.
  - Line-buffer RAM contents are not cleared; border masking makes them don't-care.
- Counters advance only on accepted pixels (iDVAL=1):
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - At row IMG_HEIGHT-1 and col IMG_WIDTH-1, both wrap to 0.
- iSOF:
  - iSOF=1 with iDVAL=1: the accepted pixel is (row 0, col 0) and the counters advance from there.
  - iSOF=1 with iDVAL=0: col and row clear to 0, and the next accepted pixel is (0,0).
- Line buffers: LB0 holds the previous line, LB1 the line before it, both addressed by col. On an accepted pixel, in one cycle:
  - read a = LB0[col] and b = LB1[col];
  - write LB0[col] <= iDATA and LB1[col] <= a.
  - Read-during-write must return the old data.
- Window: 3x3 registers pRC, R0 = oldest row, C2 = newest column. On an accepted pixel, columns shift left (C1->C0, C2->C1) and the new C2 = {b, a, iDATA} for rows 0/1/2. With iDVAL=0 the window holds.
- Arithmetic, combinational from the window:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).
  - Intermediates are at least 15 bits signed. Range is ±16380, so there is no saturation and no overflow.
  - Sign: Gx > 0 when the right side is brighter; Gy > 0 when the bottom is brighter.
- Border mask: latched with the window from the counter values of the accepted pixel. It is interior iff row >= 2 and col >= 2; otherwise outputs are forced to 0.
- Spatial alignment: each result is centred on (row-1, col-1) of the accepted pixel, i.e. the output image is offset by one line plus one pixel.
- Latency: 2 clocks.
  - Pixel accepted at edge t: the window updates at t.
  - Outputs and oDVAL=1 are registered at t+1.
  - oDVAL equals iDVAL delayed by 2 cycles.
- Idle behaviour: when oDVAL=0, oSobelX/oSobelY hold their last value.
- Gapped iDVAL must produce results identical to the back-to-back stream.
- Throughput: one pixel per clock sustained; no back-pressure.

Test Plan:
- Uniform frame, IMG_WIDTH=4, IMG_HEIGHT=4, all pixels 2048, back-to-back -> exactly 16 oDVAL pulses; every output Gx=Gy=0; first oDVAL 2 clocks after first iDVAL.
- Vertical step 4x4, cols 0-1 = 0, cols 2-3 = 4095 -> pixels (2,2),(2,3),(3,2),(3,3) give Gx=+16380, Gy=0; all 12 border outputs 0. Mirrored step gives Gx=-16380.
- Horizontal step 4x4, rows 0-1 = 0, rows 2-3 = 4095 -> interior outputs Gy=+16380, Gx=0; inverted image gives Gy=-16380.
- Vertical-step frame with iDVAL high every other cycle -> same 16-result sequence as back-to-back; outputs hold between pulses.
- After 6 pixels, assert iSOF with the 7th pixel, then send a full uniform 4x4 frame -> counters restart; the first 2 rows and first 2 columns of the new frame output 0; exactly 16 results for the new frame.
- Assert iRST mid-row 2 -> oDVAL, oSobelX and oSobelY go to 0 before the next clock edge. After release, the first accepted pixel is (0,0), and the next 2 lines output 0.
